// File: rtl/input_skew_feeder.sv
// rtl/input_skew_feeder.sv - captures BRAM row vectors and skews lane i by i cycles for the systolic array
// Tracks pass progress (FEED/DRAIN/DONE) and flags strobes that arrive after the pass is full.
module input_skew_feeder #(
  parameter int ROWS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BRAM_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable_cu,
  input  logic [ROWS*DATA_WIDTH-1:0]   bram_rdata,
  output logic [ROWS*DATA_WIDTH-1:0]   row_data,
  output logic [ROWS-1:0]              row_valid,
  output logic                         feed_busy,
  output logic                         feed_done,
  output logic                         overrun
);

  localparam int VECTORS = 2 ** BRAM_DEPTH;
  localparam int CNT_W   = BRAM_DEPTH + 1;
  localparam int DRN_W   = $clog2(ROWS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]   cap_cnt_q, cap_cnt_d;
  logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic               overrun_q, overrun_d;
  logic               feed_busy_q, feed_busy_d;
  logic               feed_done_q, feed_done_d;
  logic               capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_valid_q  <= 1'b0;
      cap_cnt_q   <= '0;
      drain_cnt_q <= '0;
      overrun_q   <= 1'b0;
      feed_busy_q <= 1'b0;
      feed_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_valid_q  <= rd_valid_d;
      cap_cnt_q   <= cap_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      overrun_q   <= overrun_d;
      feed_busy_q <= feed_busy_d;
      feed_done_q <= feed_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_valid_d  = enable_cu;
    cap_cnt_d   = cap_cnt_q;
    drain_cnt_d = drain_cnt_q;
    overrun_d   = overrun_q;
    capture     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cap_cnt_d = '0;
        if (enable_cu) state_d = S_FEED;
      end
      S_FEED: begin
        if (rd_valid_q) begin
          capture   = 1'b1;
          cap_cnt_d = cap_cnt_q + 1'b1;
          if (cap_cnt_q == CNT_W'(VECTORS - 1)) begin
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (enable_cu) overrun_d = 1'b1;
        // Last lane still needs ROWS-1 shifts before its final element reaches the output.
        if (drain_cnt_q == DRN_W'(ROWS - 1)) state_d = S_DONE;
        else drain_cnt_d = drain_cnt_q + 1'b1;
      end
      S_DONE: begin
        if (enable_cu) overrun_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    feed_busy_d = (state_d == S_FEED) || (state_d == S_DRAIN);
    feed_done_d = (state_d == S_DONE);
  end

  assign feed_busy = feed_busy_q;
  assign feed_done = feed_done_q;
  assign overrun   = overrun_q;

  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    logic [i:0][DATA_WIDTH-1:0] stg_dat_q, stg_dat_d;
    logic [i:0]                 stg_vld_q, stg_vld_d;
    logic [DATA_WIDTH-1:0]      out_dat_q, out_dat_d;
    logic                       out_vld_q, out_vld_d;

    // Stages shift every cycle so a bubble travels as an invalid slot and keeps the skew intact.
    always_comb begin
      stg_dat_d    = stg_dat_q;
      stg_vld_d    = stg_vld_q;
      stg_dat_d[0] = capture ? bram_rdata[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      stg_vld_d[0] = capture;
      for (int s = 1; s <= i; s++) begin
        stg_dat_d[s] = stg_dat_q[s-1];
        stg_vld_d[s] = stg_vld_q[s-1];
      end
      out_dat_d = stg_vld_q[i] ? stg_dat_q[i] : '0;
      out_vld_d = stg_vld_q[i];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stg_dat_q <= '0;
        stg_vld_q <= '0;
        out_dat_q <= '0;
        out_vld_q <= 1'b0;
      end else begin
        stg_dat_q <= stg_dat_d;
        stg_vld_q <= stg_vld_d;
        out_dat_q <= out_dat_d;
        out_vld_q <= out_vld_d;
      end
    end

    assign row_data[i*DATA_WIDTH +: DATA_WIDTH] = out_dat_q;
    assign row_valid[i]                         = out_vld_q;
  end

endmodule

// File: tb/tb_input_skew_feeder.sv
// tb/tb_input_skew_feeder.sv - self-checking bench for input_skew_feeder
module tb_input_skew_feeder;
  localparam int ROWS    = 4;
  localparam int DW      = 8;
  localparam int BD      = 2;
  localparam int VECTORS = 4;
  localparam int LW      = ROWS * DW;
  localparam int HIST    = 8192;

  logic          clk;
  logic          reset;
  logic          enable_cu;
  logic [LW-1:0] bram_rdata;
  logic [LW-1:0] row_data;
  logic [ROWS-1:0] row_valid;
  logic          feed_busy;
  logic          feed_done;
  logic          overrun;

  input_skew_feeder #(.ROWS(ROWS), .DATA_WIDTH(DW), .BRAM_DEPTH(BD)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable_cu  (enable_cu),
    .bram_rdata (bram_rdata),
    .row_data   (row_data),
    .row_valid  (row_valid),
    .feed_busy  (feed_busy),
    .feed_done  (feed_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference: per-edge record of captured vectors plus pass bookkeeping in edge numbers.
  logic [LW-1:0] cdat [0:HIST-1];
  bit            cvld [0:HIST-1];
  bit            in_feed, prev_en, m_ovr, directed;
  int            caps, tc, kidx, last_done, done_cnt, e0;
  logic [LW-1:0] next_bram;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] mkvec(input int k);
    logic [LW-1:0] v;
    for (int i = 0; i < ROWS; i++) v[i*DW +: DW] = DW'(16 * k + i);
    return v;
  endfunction

  task automatic model_reset();
    in_feed = 0; prev_en = 0; m_ovr = 0; caps = 0; tc = -1000;
    for (int j = 0; j < HIST; j++) begin
      cvld[j] = 0;
      cdat[j] = '0;
    end
  endtask

  // 0 idle, 1 feed, 2 drain, 3 done: the phase in force just before edge t
  function automatic int phase(input int t);
    if (in_feed) return 1;
    if (t >= tc + 1 && t <= tc + ROWS) return 2;
    if (t == tc + ROWS + 1) return 3;
    return 0;
  endfunction

  task automatic model_edge(input bit en, input logic [LW-1:0] data);
    int  ph;
    bit  cap;
    ph  = phase(cyc);
    cap = (ph == 1) && prev_en;
    cvld[cyc] = cap;
    cdat[cyc] = cap ? data : '0;
    if (cap) begin
      caps++;
      if (caps == VECTORS) begin
        in_feed = 0;
        tc = cyc;
      end
    end
    if (en && (ph == 2 || ph == 3)) m_ovr = 1;
    if (en && ph == 0) begin
      in_feed = 1;
      caps = 0;
    end
    prev_en = en;
  endtask

  task automatic check_outputs();
    logic [LW-1:0]   exp_d;
    logic [ROWS-1:0] exp_v;
    logic [LW-1:0]   src;
    int j;
    exp_d = '0;
    exp_v = '0;
    for (int i = 0; i < ROWS; i++) begin
      j = cyc - 1 - i;
      if (j >= 0 && cvld[j]) begin
        src = cdat[j];
        exp_d[i*DW +: DW] = src[i*DW +: DW];
        exp_v[i] = 1'b1;
      end
    end
    chk("row_data", 64'(row_data), 64'(exp_d));
    chk("row_valid", 64'(row_valid), 64'(exp_v));
    chk("feed_busy", 64'(feed_busy), 64'(in_feed || (cyc >= tc && cyc <= tc + ROWS - 1)));
    chk("feed_done", 64'(feed_done), 64'(cyc == tc + ROWS));
    chk("overrun", 64'(overrun), 64'(m_ovr));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_row_data"}, 64'(row_data), 64'd0);
    chk({tag, "_row_valid"}, 64'(row_valid), 64'd0);
    chk({tag, "_busy"}, 64'(feed_busy), 64'd0);
    chk({tag, "_done"}, 64'(feed_done), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
  endtask

  task automatic tick(input bit en);
    enable_cu  = en;
    bram_rdata = next_bram;
    @(posedge clk);
    cyc++;
    model_edge(en, bram_rdata);
    #1;
    check_outputs();
    if (feed_done === 1'b1) begin
      last_done = cyc;
      done_cnt++;
    end
    if (en) begin
      next_bram = directed ? mkvec(kidx) : LW'($urandom);
      kidx++;
    end else begin
      next_bram = LW'($urandom);
    end
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, then holds for a few edges.
  task automatic do_reset(input int hold);
    #2 reset = 1'b1;
    #1;
    chk_zero("async_reset");
    model_reset();
    repeat (hold) begin
      @(posedge clk);
      cyc++;
      #1;
      chk_zero("in_reset");
    end
    reset     = 1'b0;
    enable_cu = 1'b0;
    kidx      = 0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick(1'b0);
      n++;
    end
    chk("wait_done_timeout", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable_cu = 1'b0; bram_rdata = '0; next_bram = '0;
    directed = 1; kidx = 0; last_done = -1; done_cnt = 0;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      cyc++;
      #1;
      chk_zero("reset_hold");
    end
    reset = 1'b0;
    repeat (10) tick(1'b0);

    // continuous pass
    kidx = 0; done_cnt = 0; e0 = cyc + 1;
    repeat (4) tick(1'b1);
    repeat (8) tick(1'b0);
    chk("cont_done_edge", 64'(last_done), 64'(e0 + 8));
    chk("cont_done_count", 64'(done_cnt), 64'd1);

    // bubble pass 1,1,0,1,1
    kidx = 0; done_cnt = 0; e0 = cyc + 1;
    tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b1);
    repeat (9) tick(1'b0);
    chk("bubble_done_edge", 64'(last_done), 64'(e0 + 9));
    chk("bubble_done_count", 64'(done_cnt), 64'd1);

    // overrun during drain
    kidx = 0; done_cnt = 0; e0 = cyc + 1;
    repeat (4) tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    repeat (10) tick(1'b0);
    chk("overrun_sticky", 64'(overrun), 64'd1);
    chk("overrun_done_count", 64'(done_cnt), 64'd1);
    chk("overrun_done_edge", 64'(last_done), 64'(e0 + 8));

    // reset two edges after the first capture, then a clean pass
    do_reset(2);
    kidx = 0; done_cnt = 0;
    repeat (4) tick(1'b1);
    do_reset(1);
    repeat (10) tick(1'b0);
    chk("aborted_no_done", 64'(done_cnt), 64'd0);
    kidx = 0; done_cnt = 0; e0 = cyc + 1;
    repeat (4) tick(1'b1);
    repeat (8) tick(1'b0);
    chk("post_reset_done_edge", 64'(last_done), 64'(e0 + 8));

    // back-to-back passes
    kidx = 0; done_cnt = 0;
    repeat (4) tick(1'b1);
    wait_done(20);
    tick(1'b0);
    kidx = 0; done_cnt = 0; e0 = cyc + 1;
    repeat (4) tick(1'b1);
    repeat (8) tick(1'b0);
    chk("b2b_done_edge", 64'(last_done), 64'(e0 + 8));
    chk("b2b_no_overrun", 64'(overrun), 64'd0);

    // randomized traffic with a reset in the middle
    directed = 0;
    repeat (400) tick($urandom_range(0, 3) != 0);
    do_reset(2);
    repeat (400) tick($urandom_range(0, 4) != 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
